// File: rtl/ant_colony_scheduler_pkg.sv
// Shared parameters, state and memory-op encodings for the ant colony scheduler.
package ant_colony_scheduler_pkg;
    localparam int X_bits   = 6;
    localparam int Y_bits   = 6;
    localparam int ANT_bits = 2 * X_bits + 2 * Y_bits + 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN_WAIT,
        SERVICE,
        UPDATE
    } sched_state_t;

    typedef enum logic {
        MEM_OP_CLEAR   = 1'b0,
        MEM_OP_DEPOSIT = 1'b1
    } mem_op_t;

    localparam logic [7:0] LFSR_INIT = 8'hA5;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; a nonzero state never reaches zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
endpackage

// File: rtl/ant_colony_scheduler_if.sv
// Control, per-ant status and sugar-map write bundle between the scheduler and its environment.
interface ant_colony_scheduler_if #(
    parameter int NUM_ANTS = 8
);
    import ant_colony_scheduler_pkg::*;

    logic                               start;
    logic                               stop;
    logic                               tick;
    logic [X_bits-1:0]                  colony_x;
    logic [Y_bits-1:0]                  colony_y;
    logic [NUM_ANTS-1:0]                collect_req;
    logic [NUM_ANTS-1:0]                drop_req;
    logic [NUM_ANTS-1:0][X_bits-1:0]    ant_x;
    logic [NUM_ANTS-1:0][Y_bits-1:0]    ant_y;
    logic                               mem_ack;

    logic                               setup_phase;
    logic [NUM_ANTS-1:0]                ant_set;
    logic [ANT_bits-1:0]                ant_d_in;
    logic [7:0]                         ant_seed;
    logic                               update_flag;
    logic                               mem_req;
    logic                               mem_op;
    logic [X_bits-1:0]                  mem_x;
    logic [Y_bits-1:0]                  mem_y;
    logic [15:0]                        sugar_delivered;
    logic                               overrun;

    modport master (
        input  start, stop, tick, colony_x, colony_y, collect_req, drop_req,
               ant_x, ant_y, mem_ack,
        output setup_phase, ant_set, ant_d_in, ant_seed, update_flag,
               mem_req, mem_op, mem_x, mem_y, sugar_delivered, overrun
    );

    modport slave (
        output start, stop, tick, colony_x, colony_y, collect_req, drop_req,
               ant_x, ant_y, mem_ack,
        input  setup_phase, ant_set, ant_d_in, ant_seed, update_flag,
               mem_req, mem_op, mem_x, mem_y, sugar_delivered, overrun
    );
endinterface

// File: rtl/ant_colony_scheduler_priority_enc.sv
// Lowest-set-bit encoder used to pick the next ant to service.
module ant_priority_enc #(
    parameter  int NUM_ANTS = 8,
    localparam int IDX_W    = $clog2(NUM_ANTS)
) (
    input  logic [NUM_ANTS-1:0] req,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_ANTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ant_colony_scheduler.sv
// Sequences ant setup, then per game tick drains collect/drop requests into sugar-map writes.
module ant_colony_scheduler
    import ant_colony_scheduler_pkg::*;
#(
    parameter int NUM_ANTS = 8
) (
    input  logic                   game_clk,
    input  logic                   RESET,
    ant_colony_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(NUM_ANTS);

    sched_state_t                    state, state_nxt;
    logic [IDX_W-1:0]                idx;
    logic [2:0]                      idx_lo;
    logic [7:0]                      lfsr;
    logic [NUM_ANTS-1:0]             pending;
    logic [NUM_ANTS-1:0]             kind;
    logic [NUM_ANTS-1:0][X_bits-1:0] pos_x;
    logic [NUM_ANTS-1:0][Y_bits-1:0] pos_y;
    logic                            stop_lat;
    logic [15:0]                     sugar_cnt;
    logic                            overrun_q;
    logic [IDX_W-1:0]                grant;
    logic                            grant_vld;
    logic                            ack_take;
    logic                            tick_take;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ant_priority_enc #(.NUM_ANTS(NUM_ANTS)) u_enc (
        .req   (pending),
        .idx   (grant),
        .valid (grant_vld)
    );

    assign idx_lo    = 3'(idx);
    assign ack_take  = (state == SERVICE) && grant_vld && bus.mem_ack;
    assign tick_take = (state == RUN_WAIT) && !stop_lat && bus.tick;

    always_comb begin
        state_nxt           = state;
        bus.setup_phase     = 1'b1;
        bus.ant_set         = '0;
        bus.ant_d_in        = '0;
        bus.ant_seed        = '0;
        bus.update_flag     = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_op          = MEM_OP_CLEAR;
        bus.mem_x           = '0;
        bus.mem_y           = '0;
        bus.sugar_delivered = '0;
        bus.overrun         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = SETUP;
            end
            SETUP: begin
                if (idx == IDX_W'(NUM_ANTS - 1)) state_nxt = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (stop_lat)
                    state_nxt = IDLE;
                else if (bus.tick)
                    state_nxt = (|(bus.collect_req | bus.drop_req)) ? SERVICE : UPDATE;
            end
            SERVICE: begin
                if (!grant_vld) state_nxt = UPDATE;
            end
            UPDATE: begin
                state_nxt = RUN_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are held at their reset values for as long as RESET is asserted.
        if (!RESET) begin
            bus.sugar_delivered = sugar_cnt;
            bus.overrun         = overrun_q;
            case (state)
                SETUP: begin
                    bus.ant_set  = NUM_ANTS'(1) << idx;
                    bus.ant_d_in = {bus.colony_x, bus.colony_y, 1'b0, idx_lo,
                                    bus.colony_x, bus.colony_y};
                    bus.ant_seed = lfsr;
                end
                RUN_WAIT: bus.setup_phase = 1'b0;
                SERVICE: begin
                    bus.setup_phase = 1'b0;
                    if (grant_vld) begin
                        bus.mem_req = 1'b1;
                        bus.mem_op  = kind[grant] ? MEM_OP_CLEAR : MEM_OP_DEPOSIT;
                        bus.mem_x   = pos_x[grant];
                        bus.mem_y   = pos_y[grant];
                    end
                end
                UPDATE: begin
                    bus.setup_phase = 1'b0;
                    bus.update_flag = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge game_clk) begin
        if (RESET) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= '0;
            kind      <= '0;
            stop_lat  <= 1'b0;
            lfsr      <= LFSR_INIT;
            sugar_cnt <= '0;
            overrun_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.stop && state != IDLE && !(state == RUN_WAIT && stop_lat))
                stop_lat <= 1'b1;
            if (bus.tick && (state == SETUP || state == SERVICE || state == UPDATE))
                overrun_q <= 1'b1;
            case (state)
                IDLE: idx <= '0;
                SETUP: begin
                    idx  <= idx + IDX_W'(1);
                    lfsr <= lfsr_next(lfsr);
                end
                RUN_WAIT: begin
                    if (stop_lat) begin
                        pending  <= '0;
                        stop_lat <= 1'b0;
                    end else if (bus.tick) begin
                        pending <= bus.collect_req | bus.drop_req;
                        kind    <= bus.collect_req;
                    end
                end
                SERVICE: begin
                    if (ack_take) begin
                        pending[grant] <= 1'b0;
                        if (!kind[grant]) sugar_cnt <= sat_inc(sugar_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

    // Drop-only ants target the nest, so their write address is captured as the colony.
    always_ff @(posedge game_clk) begin
        if (tick_take) begin
            for (int i = 0; i < NUM_ANTS; i++) begin
                if (bus.drop_req[i] && !bus.collect_req[i]) begin
                    pos_x[i] <= bus.colony_x;
                    pos_y[i] <= bus.colony_y;
                end else begin
                    pos_x[i] <= bus.ant_x[i];
                    pos_y[i] <= bus.ant_y[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_ant_colony_scheduler.sv
// Randomized bench for ant_colony_scheduler with a grant-queue reference model.
module tb_ant_colony_scheduler;
    localparam int N  = 8;
    localparam int XB = ant_colony_scheduler_pkg::X_bits;
    localparam int YB = ant_colony_scheduler_pkg::Y_bits;
    localparam int AB = ant_colony_scheduler_pkg::ANT_bits;

    typedef struct {
        int            idx;
        logic          op;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
    } grant_t;

    logic game_clk = 1'b0;
    logic RESET    = 1'b1;
    always #5 game_clk = ~game_clk;

    ant_colony_scheduler_if #(.NUM_ANTS(N)) bus ();
    ant_colony_scheduler #(.NUM_ANTS(N)) dut (
        .game_clk (game_clk),
        .RESET    (RESET),
        .bus      (bus.master)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_lfsr  = 8'hA5;
    int         m_sugar = 0;

    task automatic cyc();
        @(posedge game_clk);
        #1;
    endtask

    function automatic logic [7:0] model_lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    task automatic randomize_positions();
        for (int i = 0; i < N; i++) begin
            bus.ant_x[i] = XB'($urandom);
            bus.ant_y[i] = YB'($urandom);
        end
    endtask

    // Drives one tick from RUN_WAIT and checks every grant, the update pulse and the count.
    task automatic serve_tick(input logic [N-1:0] col, input logic [N-1:0] drp,
                              input int delay, input bit scramble);
        grant_t q[$];
        grant_t g;
        int     waited;
        for (int i = 0; i < N; i++) begin
            if (col[i] || drp[i]) begin
                g.idx = i;
                g.op  = col[i] ? 1'b0 : 1'b1;
                g.x   = col[i] ? bus.ant_x[i] : bus.colony_x;
                g.y   = col[i] ? bus.ant_y[i] : bus.colony_y;
                q.push_back(g);
            end
        end
        bus.collect_req = col;
        bus.drop_req    = drp;
        bus.tick        = 1'b1;
        cyc();
        bus.tick        = 1'b0;
        bus.collect_req = '0;
        bus.drop_req    = '0;
        if (scramble) randomize_positions();
        while (q.size() > 0) begin
            g = q.pop_front();
            waited = 0;
            while (bus.mem_req !== 1'b1 && waited < 20) begin
                cyc();
                waited++;
            end
            n_tests++;
            if (bus.mem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL grant_timeout ant%0d: mem_req=%b, required 1", g.idx, bus.mem_req);
                return;
            end
            n_tests++;
            if ({bus.mem_op, bus.mem_x, bus.mem_y} !== {g.op, g.x, g.y}) begin
                n_fail++;
                $display("FAIL grant ant%0d: got op=%b x=%0d y=%0d, required op=%b x=%0d y=%0d",
                         g.idx, bus.mem_op, bus.mem_x, bus.mem_y, g.op, g.x, g.y);
            end
            n_tests++;
            if (bus.update_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL update_with_req ant%0d: update_flag=%b, required 0", g.idx, bus.update_flag);
            end
            for (int d = 0; d < delay; d++) begin
                cyc();
                n_tests++;
                if ({bus.mem_req, bus.mem_op, bus.mem_x, bus.mem_y} !== {1'b1, g.op, g.x, g.y}) begin
                    n_fail++;
                    $display("FAIL mem_stable ant%0d wait%0d: got req=%b op=%b x=%0d y=%0d, required req=1 op=%b x=%0d y=%0d",
                             g.idx, d, bus.mem_req, bus.mem_op, bus.mem_x, bus.mem_y, g.op, g.x, g.y);
                end
            end
            bus.mem_ack = 1'b1;
            cyc();
            bus.mem_ack = 1'b0;
            if (g.op) m_sugar = (m_sugar < 65535) ? m_sugar + 1 : 65535;
        end
        waited = 0;
        while (bus.update_flag !== 1'b1 && waited < 10) begin
            n_tests++;
            if (bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL extra_grant: mem_req=%b x=%0d, required 0", bus.mem_req, bus.mem_x);
            end
            cyc();
            waited++;
        end
        n_tests++;
        if (bus.update_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL update_timeout: update_flag=%b, required 1", bus.update_flag);
            return;
        end
        n_tests++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL update_and_req: mem_req=%b during update, required 0", bus.mem_req);
        end
        n_tests++;
        if (bus.sugar_delivered !== 16'(m_sugar)) begin
            n_fail++;
            $display("FAIL sugar_count: got %0d, required %0d", bus.sugar_delivered, m_sugar);
        end
        cyc();
        n_tests++;
        if ({bus.update_flag, bus.setup_phase} !== 2'b00) begin
            n_fail++;
            $display("FAIL update_pulse: got update_flag=%b setup_phase=%b, required 0 0",
                     bus.update_flag, bus.setup_phase);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) cyc();
        n_tests++;
        if ({bus.setup_phase, bus.ant_set, bus.ant_d_in, bus.ant_seed, bus.update_flag,
             bus.mem_req, bus.mem_op, bus.mem_x, bus.mem_y, bus.sugar_delivered, bus.overrun}
            !== {1'b1, {(N + AB + 8 + 3 + XB + YB + 17){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: setup_phase=%b ant_set=%h seed=%h mem_req=%b sugar=%0d overrun=%b, required 1 and all zero",
                     bus.setup_phase, bus.ant_set, bus.ant_seed, bus.mem_req, bus.sugar_delivered, bus.overrun);
        end
        RESET = 1'b0;
        m_lfsr  = 8'hA5;
        m_sugar = 0;
        cyc();
        n_tests++;
        if ({bus.setup_phase, bus.ant_set, bus.mem_req} !== {1'b1, {N{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_outputs: setup_phase=%b ant_set=%h mem_req=%b, required 1 00 0",
                     bus.setup_phase, bus.ant_set, bus.mem_req);
        end
    endtask

    task automatic test_setup_sweep();
        logic [AB-1:0] exp_d;
        bus.colony_x = XB'($urandom);
        bus.colony_y = YB'($urandom);
        bus.start    = 1'b1;
        cyc();
        bus.start    = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_d = {bus.colony_x, bus.colony_y, 1'b0, 3'(k), bus.colony_x, bus.colony_y};
            n_tests++;
            if (bus.ant_set !== N'(1 << k) || bus.setup_phase !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_set k=%0d: got ant_set=%h setup_phase=%b, required %h 1",
                         k, bus.ant_set, bus.setup_phase, N'(1 << k));
            end
            n_tests++;
            if (bus.ant_seed !== m_lfsr) begin
                n_fail++;
                $display("FAIL sweep_seed k=%0d: got %h, required %h", k, bus.ant_seed, m_lfsr);
            end
            n_tests++;
            if (bus.ant_d_in !== exp_d) begin
                n_fail++;
                $display("FAIL sweep_d_in k=%0d: got %h, required %h", k, bus.ant_d_in, exp_d);
            end
            m_lfsr = model_lfsr_step(m_lfsr);
            cyc();
        end
        n_tests++;
        if ({bus.setup_phase, bus.ant_set} !== {1'b0, {N{1'b0}}}) begin
            n_fail++;
            $display("FAIL sweep_end: setup_phase=%b ant_set=%h, required 0 00", bus.setup_phase, bus.ant_set);
        end
    endtask

    task automatic test_service_order();
        randomize_positions();
        serve_tick(8'b0010_0100, 8'h00, 1, 1'b1);
    endtask

    task automatic test_drop_path();
        randomize_positions();
        n_tests++;
        if (bus.sugar_delivered !== 16'd0) begin
            n_fail++;
            $display("FAIL drop_pre_count: got %0d, required 0", bus.sugar_delivered);
        end
        serve_tick(8'h00, 8'h80, 5, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            randomize_positions();
            serve_tick(N'($urandom) & N'($urandom), N'($urandom), $urandom_range(0, 3), 1'b1);
        end
    endtask

    task automatic test_ack_ignored();
        bus.mem_ack = 1'b1;
        repeat (4) cyc();
        bus.mem_ack = 1'b0;
        n_tests++;
        if (bus.sugar_delivered !== 16'(m_sugar) || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: sugar=%0d mem_req=%b, required %0d 0", bus.sugar_delivered, bus.mem_req, m_sugar);
        end
        randomize_positions();
        serve_tick(8'h10, 8'h01, 0, 1'b0);
    endtask

    task automatic test_overrun();
        int waited = 0;
        int upd    = 0;
        int mreq   = 0;
        n_tests++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre: got %b, required 0", bus.overrun);
        end
        bus.drop_req = 8'h08;
        bus.tick     = 1'b1;
        cyc();
        bus.tick     = 1'b0;
        bus.drop_req = '0;
        while (bus.mem_req !== 1'b1 && waited < 10) begin
            cyc();
            waited++;
        end
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        n_tests++;
        if (bus.overrun !== 1'b1 || bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: overrun=%b mem_req=%b, required 1 1", bus.overrun, bus.mem_req);
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        m_sugar = (m_sugar < 65535) ? m_sugar + 1 : 65535;
        repeat (8) begin
            upd  += int'(bus.update_flag);
            mreq += int'(bus.mem_req);
            cyc();
        end
        n_tests++;
        if (upd != 1 || mreq != 0) begin
            n_fail++;
            $display("FAIL overrun_drop: update pulses=%0d grants=%0d, required 1 0", upd, mreq);
        end
        n_tests++;
        if (bus.sugar_delivered !== 16'(m_sugar)) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d, required %0d", bus.sugar_delivered, m_sugar);
        end
    endtask

    task automatic test_stop();
        int waited = 0;
        randomize_positions();
        bus.collect_req = 8'h02;
        bus.tick        = 1'b1;
        cyc();
        bus.tick        = 1'b0;
        bus.collect_req = '0;
        bus.stop        = 1'b1;
        cyc();
        bus.stop        = 1'b0;
        repeat (2) begin
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.mem_x !== bus.ant_x[1]) begin
                n_fail++;
                $display("FAIL stop_inflight: mem_req=%b x=%0d, required 1 %0d", bus.mem_req, bus.mem_x, bus.ant_x[1]);
            end
            cyc();
        end
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        while (bus.setup_phase !== 1'b1 && waited < 10) begin
            n_tests++;
            if (bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_regrant: mem_req=%b, required 0", bus.mem_req);
            end
            cyc();
            waited++;
        end
        n_tests++;
        if (bus.setup_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_idle: setup_phase=%b after stop, required 1", bus.setup_phase);
        end
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        cyc();
        n_tests++;
        if ({bus.setup_phase, bus.ant_set} !== {1'b1, {N{1'b0}}}) begin
            n_fail++;
            $display("FAIL idle_hold: setup_phase=%b ant_set=%h, required 1 00", bus.setup_phase, bus.ant_set);
        end
        test_setup_sweep();
        randomize_positions();
        serve_tick(8'h00, 8'h20, 1, 1'b0);
    endtask

    task automatic test_saturation();
        force dut.sugar_cnt = 16'hFFFF;
        cyc();
        release dut.sugar_cnt;
        cyc();
        m_sugar = 65535;
        n_tests++;
        if (bus.sugar_delivered !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_preload: got %h, required FFFF", bus.sugar_delivered);
        end
        randomize_positions();
        serve_tick(8'h00, 8'h41, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        randomize_positions();
        bus.drop_req    = 8'h01;
        bus.collect_req = 8'h10;
        bus.tick        = 1'b1;
        cyc();
        bus.tick        = 1'b0;
        bus.drop_req    = '0;
        bus.collect_req = '0;
        while (bus.mem_req !== 1'b1 && waited < 10) begin
            cyc();
            waited++;
        end
        cyc();
        RESET = 1'b1;
        cyc();
        n_tests++;
        if ({bus.mem_req, bus.setup_phase, bus.update_flag, bus.overrun} !== 4'b0100
            || bus.sugar_delivered !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: mem_req=%b setup_phase=%b update=%b overrun=%b sugar=%0d, required 0 1 0 0 0",
                     bus.mem_req, bus.setup_phase, bus.update_flag, bus.overrun, bus.sugar_delivered);
        end
        RESET   = 1'b0;
        m_lfsr  = 8'hA5;
        m_sugar = 0;
        cyc();
        test_setup_sweep();
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.tick        = 1'b0;
        bus.colony_x    = '0;
        bus.colony_y    = '0;
        bus.collect_req = '0;
        bus.drop_req    = '0;
        bus.ant_x       = '0;
        bus.ant_y       = '0;
        bus.mem_ack     = 1'b0;
        test_reset();
        test_setup_sweep();
        test_service_order();
        test_drop_path();
        test_random();
        test_ack_ignored();
        test_overrun();
        test_stop();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time budget, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
